somador_serial: RTL and testbench

Bit-serial adder built around a one-bit full-adder cell. It loads two WIDTH-bit operands, presents them LSB-first to the full adder one bit per clock, and keeps the carry in a flip-flop between bits. The sum is assembled in a shift register. This is the area-minimal alternative to the ripple-carry adder: it trades WIDTH cycles of latency for a single adder cell.

---
 rtl/somador_serial.sv | 110 +++++++++++
 tb/tb_somador_serial.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/somador_serial.sv
// Bit-serial adder: one full-adder cell, carry held in a flop; `SOMADOR_SERIAL_OVERFLOW_EN adds estouro.
// Latency: soma/tSaida/pronto WIDTH edges after the start edge; next start accepted WIDTH+2 edges after it.
// Backpressure: none; iniciar is dropped while ocupado=1 and during the FIM cycle, no queuing.
module somador_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             iniciar,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             tEntrada,
  output logic [WIDTH-1:0] soma,
  output logic             tSaida,
  output logic             ocupado,
  output logic             pronto
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
  ,
  output logic             estouro
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    SOMANDO = 2'd1,
    FIM     = 2'd2
  } estado_t;

  estado_t estado, proximo;

  logic [WIDTH-1:0] regA, regB;
  // The final sum bit goes straight into soma, so the shifter's LSB slot is never needed.
  logic [WIDTH-1:1] regS;
  logic             carry;
  logic [CW-1:0]    contador;

  logic s, c, ultimoBit;

  assign s         = regA[0] ^ regB[0] ^ carry;
  assign c         = (regA[0] & regB[0]) | (regA[0] & carry) | (regB[0] & carry);
  assign ultimoBit = (contador == CW'(WIDTH - 1));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) estado <= OCIOSO;
    else         estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:  if (iniciar) proximo = SOMANDO;
      SOMANDO: if (ultimoBit) proximo = FIM;
      FIM:     proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      regA     <= '0;
      regB     <= '0;
      regS     <= '0;
      carry    <= 1'b0;
      contador <= '0;
      soma     <= '0;
      tSaida   <= 1'b0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
      estouro  <= 1'b0;
`endif
    end else begin
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            regA     <= a;
            regB     <= b;
            carry    <= tEntrada;
            contador <= '0;
            ocupado  <= 1'b1;
          end
        end
        SOMANDO: begin
          regA     <= {1'b0, regA[WIDTH-1:1]};
          regB     <= {1'b0, regB[WIDTH-1:1]};
          regS     <= {s, regS[WIDTH-1:1]} >> 1;
          carry    <= c;
          contador <= contador + CW'(1);
          if (ultimoBit) begin
            soma    <= {s, regS[WIDTH-1:1]};
            tSaida  <= c;
            pronto  <= 1'b1;
            ocupado <= 1'b0;
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
            // carry still holds the carry into the MSB on this edge
            estouro <= carry ^ c;
`endif
          end
        end
        FIM: begin
          pronto <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_somador_serial.sv
// Bench for somador_serial: cycle model for the WIDTH=8 instance plus directed and swept checks at WIDTH=2 and 32.
module tb_somador_serial;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetN;

  logic       iniciar, tEntrada, tSaida, ocupado, pronto;
  logic [7:0] a, b, soma;
  logic       i2, c2, t2, o2, p2;
  logic [1:0] a2, b2, s2;
  logic        i32, c32, t32, o32, p32;
  logic [31:0] a32, b32, s32;
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
  logic estouro, e2, e32;
`endif

  somador_serial #(.WIDTH(8)) dut (
    .clock(clock), .resetN(resetN), .iniciar(iniciar), .a(a), .b(b), .tEntrada(tEntrada),
    .soma(soma), .tSaida(tSaida), .ocupado(ocupado), .pronto(pronto)
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    , .estouro(estouro)
`endif
  );

  somador_serial #(.WIDTH(2)) dut2 (
    .clock(clock), .resetN(resetN), .iniciar(i2), .a(a2), .b(b2), .tEntrada(c2),
    .soma(s2), .tSaida(t2), .ocupado(o2), .pronto(p2)
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    , .estouro(e2)
`endif
  );

  somador_serial #(.WIDTH(32)) dut32 (
    .clock(clock), .resetN(resetN), .iniciar(i32), .a(a32), .b(b32), .tEntrada(c32),
    .soma(s32), .tSaida(t32), .ocupado(o32), .pronto(p32)
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    , .estouro(e32)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit chkOn  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model of the WIDTH=8 instance: an accepted start at edge k yields its result at k+8,
  // busy over [k, k+8), and the next start is accepted no earlier than k+10.
  int         cyc, startAt, doneAt, freeAt;
  logic [7:0] mSoma, pendS;
  logic       mT, mE, mOcup, mPronto, pendT, pendE;

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cyc <= 0; startAt <= -100; doneAt <= -100; freeAt <= 0;
      mSoma <= '0; mT <= 1'b0; mE <= 1'b0; mOcup <= 1'b0; mPronto <= 1'b0;
      pendS <= '0; pendT <= 1'b0; pendE <= 1'b0;
    end else begin : mdl
      int st, dn;
      logic [8:0] full;
      st = startAt;
      dn = doneAt;
      if (cyc >= freeAt && iniciar) begin
        st   = cyc;
        dn   = cyc + 8;
        full = {1'b0, a} + {1'b0, b} + 9'(tEntrada);
        freeAt <= cyc + 10;
        pendS  <= full[7:0];
        pendT  <= full[8];
        pendE  <= (a[7] == b[7]) && (full[7] != a[7]);
      end
      startAt <= st;
      doneAt  <= dn;
      mOcup   <= (cyc >= st) && (cyc < dn);
      mPronto <= (cyc == dn);
      if (cyc == dn) begin
        mSoma <= pendS;
        mT    <= pendT;
        mE    <= pendE;
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clock) begin
    if (chkOn) begin
      chk("cyc soma", 32'(soma), 32'(mSoma));
      chk("cyc tSaida", 32'(tSaida), 32'(mT));
      chk("cyc ocupado", 32'(ocupado), 32'(mOcup));
      chk("cyc pronto", 32'(pronto), 32'(mPronto));
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
      chk("cyc estouro", 32'(estouro), 32'(mE));
`endif
    end
  end

  task automatic runOp8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic et, input logic ee, input string nm);
    int n;
    @(posedge clock); #2;
    a = ta; b = tb; tEntrada = tc; iniciar = 1'b1;
    @(posedge clock); #2;
    iniciar = 1'b0; a = ~ta; b = ~tb; tEntrada = ~tc;
    n = 0;
    while (n < 40) begin
      @(negedge clock);
      if (pronto) break;
      @(posedge clock);
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'd8);
    chk({nm, " soma"}, 32'(soma), 32'(es));
    chk({nm, " tSaida"}, 32'(tSaida), 32'(et));
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    chk({nm, " estouro"}, 32'(estouro), 32'(ee));
`else
    if (ee === 1'bx) chk({nm, " estouro arg"}, 32'(ee), 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pulses, n;
    bit first;
    logic [2:0]  f2;
    logic [32:0] f32;

    resetN = 1'b1; iniciar = 1'b0; a = '0; b = '0; tEntrada = 1'b0;
    i2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0;
    i32 = 1'b0; a32 = '0; b32 = '0; c32 = 1'b0;
    #1 resetN = 1'b0;
    #2;
    chk("reset soma", 32'(soma), 32'd0);
    chk("reset tSaida", 32'(tSaida), 32'd0);
    chk("reset ocupado", 32'(ocupado), 32'd0);
    chk("reset pronto", 32'(pronto), 32'd0);
    chk("reset soma32", s32, 32'd0);
    chkOn = 1'b1;
    @(posedge clock); @(posedge clock); #2;
    resetN = 1'b1;

    runOp8(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, "basic");
    runOp8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "wrap1");
    runOp8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "wrap2");
    runOp8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, "ovfcin");

    // iniciar held high with operands changing every cycle
    @(posedge clock); #2;
    a = 8'h11; b = 8'h22; tEntrada = 1'b0; iniciar = 1'b1;
    pulses = 0; first = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); #2;
      a = 8'($urandom); b = 8'($urandom); tEntrada = 1'($urandom);
      @(negedge clock);
      if (pronto) begin
        pulses++;
        if (first) chk("busy first soma", 32'(soma), 32'h33);
        first = 1'b0;
      end
    end
    iniciar = 1'b0;
    chk("busy pulses", 32'(pulses), 32'd3);
    repeat (3) @(posedge clock);

    runOp8(8'h40, 8'h41, 1'b0, 8'h81, 1'b0, 1'b1, "prereset");
    @(posedge clock); #2;
    a = 8'hAA; b = 8'h57; tEntrada = 1'b1; iniciar = 1'b1;
    @(posedge clock); #2;
    iniciar = 1'b0;
    repeat (4) @(posedge clock);
    #2 resetN = 1'b0;
    #1;
    chk("midrst soma", 32'(soma), 32'd0);
    chk("midrst tSaida", 32'(tSaida), 32'd0);
    chk("midrst ocupado", 32'(ocupado), 32'd0);
    chk("midrst pronto", 32'(pronto), 32'd0);
`ifdef SOMADOR_SERIAL_OVERFLOW_EN
    chk("midrst estouro", 32'(estouro), 32'd0);
`endif
    @(posedge clock); #2;
    resetN = 1'b1;
    runOp8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, "postreset");

    for (int t = 0; t < 8; t++) begin
      @(posedge clock); #2;
      a2 = 2'($urandom); b2 = 2'($urandom); c2 = 1'($urandom); i2 = 1'b1;
      f2 = {1'b0, a2} + {1'b0, b2} + 3'(c2);
      @(posedge clock); #2;
      i2 = 1'b0; a2 = ~a2; b2 = ~b2;
      n = 0;
      while (n < 20) begin
        @(negedge clock);
        if (p2) break;
        @(posedge clock);
        n++;
      end
      chk("w2 latency", 32'(n), 32'd2);
      chk("w2 soma", 32'(s2), 32'(f2[1:0]));
      chk("w2 tSaida", 32'(t2), 32'(f2[2]));
      @(posedge clock);
    end

    for (int t = 0; t < 6; t++) begin
      @(posedge clock); #2;
      a32 = (t == 0) ? 32'hFFFF_FFFF : $urandom;
      b32 = (t == 0) ? 32'h0000_0001 : $urandom;
      c32 = (t == 0) ? 1'b0 : 1'($urandom);
      i32 = 1'b1;
      f32 = {1'b0, a32} + {1'b0, b32} + 33'(c32);
      @(posedge clock); #2;
      i32 = 1'b0; a32 = ~a32;
      n = 0;
      while (n < 60) begin
        @(negedge clock);
        if (p32) break;
        @(posedge clock);
        n++;
      end
      chk("w32 latency", 32'(n), 32'd32);
      chk("w32 soma", s32, f32[31:0]);
      chk("w32 tSaida", 32'(t32), 32'(f32[32]));
      @(posedge clock);
    end

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
